// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one word-addressed data-memory access per
// load/store, stalls the pipeline while it is outstanding and formats load data.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int TIMER_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        busy_wait,
    output logic        misaligned,
    output logic        bus_error
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]         state;
    logic [2:0]         f3_q;
    logic [1:0]         lane_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [TIMER_W-1:0] timer;

    logic               request;
    logic               legal;
    logic               issue;
    logic               timeout;
    logic [3:0]         be_next;
    logic [31:0]        wdata_next;
    logic [31:0]        rword_sh;
    logic [31:0]        load_fmt;

    // A store takes priority over a load, so store-illegal width codes reject
    // the whole request even if mem_read is also set.
    always_comb begin
        request = mem_read | mem_write;
        legal   = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~alu_result[0];
            3'b010:  legal = (alu_result[1:0] == 2'b00);
            3'b100:  legal = ~mem_write;
            3'b101:  legal = ~mem_write & ~alu_result[0];
            default: legal = 1'b0;
        endcase
        issue      = (state == IDLE) && request && legal;
        misaligned = request && !legal;
    end

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << alu_result[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << alu_result[1:0];
                wdata_next = {2{store_data[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = store_data;
            end
        endcase
    end

    // Halfword accesses are aligned, so one byte-granular shift serves both widths.
    always_comb begin
        rword_sh = dmem_rdata >> {lane_q, 3'b000};
        load_fmt = dmem_rdata;
        case (f3_q)
            3'b000:  load_fmt = {{24{rword_sh[7]}}, rword_sh[7:0]};
            3'b001:  load_fmt = {{16{rword_sh[15]}}, rword_sh[15:0]};
            3'b100:  load_fmt = {24'd0, rword_sh[7:0]};
            3'b101:  load_fmt = {16'd0, rword_sh[15:0]};
            default: load_fmt = dmem_rdata;
        endcase
    end

    assign timeout   = (timer == TIMER_W'(TIMEOUT - 1));
    assign dmem_req  = (state == ACCESS);
    assign dmem_we   = we_q & dmem_req;
    assign dmem_be   = be_q & {4{dmem_req}};
    assign busy_wait = ~reset & (issue | dmem_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            f3_q       <= 3'd0;
            lane_q     <= 2'd0;
            we_q       <= 1'b0;
            be_q       <= 4'd0;
            timer      <= '0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            load_data  <= 32'd0;
            bus_error  <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        dmem_addr  <= {alu_result[31:2], 2'b00};
                        dmem_wdata <= wdata_next;
                        we_q       <= mem_write;
                        be_q       <= be_next;
                        f3_q       <= funct3;
                        lane_q     <= alu_result[1:0];
                        timer      <= '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        if (!we_q) begin
                            load_data <= load_fmt;
                        end
                        timer <= '0;
                        state <= DONE;
                    end else if (timeout) begin
                        bus_error <= 1'b1;
                        timer     <= '0;
                        state     <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// timeout/reset sequences and randomized transactions against a reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        busy_wait, misaligned, bus_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_load = 32'd0;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rd;
        int          waits;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[12];

    mem_access_unit #(.TIMEOUT(16), .TIMER_W(5)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .alu_result(alu_result), .store_data(store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .load_data(load_data), .busy_wait(busy_wait),
        .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] rd, input int waits,
                                input logic mis, input logic [3:0] be, input logic [31:0] ea,
                                input logic [31:0] wd, input logic [31:0] ld);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.sd = sd; v.rd = rd; v.waits = waits;
        v.exp_mis = mis; v.exp_be = be; v.exp_addr = ea; v.exp_wdata = wd; v.exp_load = ld;
        return v;
    endfunction

    // Reference model: access size in bytes, 0 for an illegal width code.
    function automatic int size_of(input logic wr, input logic [2:0] f3);
        if (f3 == 3'd3 || f3 >= 3'd6) return 0;
        if (wr && f3 >= 3'd3) return 0;
        return 1 << (f3 % 4);
    endfunction

    function automatic logic legal_m(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(wr, f3);
        if (sz == 0) return 1'b0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [3:0] be_m(input logic [2:0] f3, input logic [31:0] a);
        int sz = 1 << (f3 % 4);
        int mask = ((1 << sz) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] wdata_m(input logic [2:0] f3, input logic [31:0] sd);
        int sz = 1 << (f3 % 4);
        if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz = 1 << (f3 % 4);
        logic [31:0] v = rd >> (8 * (a % 4));
        logic sgn = (f3 < 3'd4);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Runs one transaction with a memory answering after 'waits' wait cycles.
    task automatic applyStimulus(input string tag, input vec_t v);
        int busy_cnt;
        logic err_seen;
        @(negedge clk);
        mem_write  = v.wr;
        mem_read   = ~v.wr;
        funct3     = v.f3;
        alu_result = v.addr;
        store_data = v.sd;
        #1;
        if (v.exp_mis) begin
            check({tag, "_mis"}, misaligned, 1);
            check({tag, "_busy"}, busy_wait, 0);
            check({tag, "_req"}, dmem_req, 0);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_req_later"}, dmem_req, 0);
            check({tag, "_load"}, load_data, v.exp_load);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            return;
        end
        check({tag, "_mis"}, misaligned, 0);
        busy_cnt = busy_wait ? 1 : 0;
        err_seen = 1'b0;
        for (int k = 0; k <= v.waits; k++) begin
            @(posedge clk);
            @(negedge clk);
            busy_cnt += busy_wait ? 1 : 0;
            err_seen |= bus_error;
            if (k == 0) begin
                check({tag, "_req"}, dmem_req, 1);
                check({tag, "_we"}, dmem_we, v.wr);
                check({tag, "_be"}, dmem_be, v.exp_be);
                check({tag, "_addr"}, dmem_addr, v.exp_addr);
                if (v.wr) check({tag, "_wdata"}, dmem_wdata, v.exp_wdata);
            end
            dmem_ready = (k == v.waits);
            dmem_rdata = v.rd;
        end
        @(posedge clk);
        @(negedge clk);
        dmem_ready = 1'b0;
        check({tag, "_busycnt"}, busy_cnt, v.waits + 2);
        check({tag, "_done"}, {dmem_req, busy_wait, bus_error | err_seen}, 3'b000);
        check({tag, "_load"}, load_data, v.exp_load);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_req"}, dmem_req, 0);
        check({tag, "_busy"}, busy_wait, 0);
        check({tag, "_load"}, load_data, 0);
        check({tag, "_addr"}, dmem_addr, 0);
        check({tag, "_wdata"}, dmem_wdata, 0);
        check({tag, "_be_we_err"}, {dmem_be, dmem_we, bus_error}, 0);
    endtask

    initial begin
        vec_t r;
        int req_cnt;
        logic early_err;

        reset = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0;
        alu_result = 0; store_data = 0; dmem_ready = 0; dmem_rdata = 0;
        #12;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b0;

        vecs[0]  = mk(0, 3'b010, 32'h0000_1004, 0, 32'hDEAD_BEEF, 2, 0, 4'b1111, 32'h1004, 0, 32'hDEAD_BEEF);
        vecs[1]  = mk(0, 3'b000, 32'h0000_2003, 0, 32'h80FF_0102, 0, 0, 4'b1000, 32'h2000, 0, 32'hFFFF_FF80);
        vecs[2]  = mk(0, 3'b100, 32'h0000_2003, 0, 32'h80FF_0102, 1, 0, 4'b1000, 32'h2000, 0, 32'h0000_0080);
        vecs[3]  = mk(1, 3'b000, 32'h0000_2002, 32'h1234_56AB, 0, 1, 0, 4'b0100, 32'h2000, 32'hABAB_ABAB, 32'h0000_0080);
        vecs[4]  = mk(1, 3'b001, 32'h0000_2002, 32'h1234_56AB, 0, 0, 0, 4'b1100, 32'h2000, 32'h56AB_56AB, 32'h0000_0080);
        vecs[5]  = mk(0, 3'b010, 32'h0000_1002, 0, 0, 0, 1, 0, 0, 0, 32'h0000_0080);
        vecs[6]  = mk(0, 3'b001, 32'h0000_1001, 0, 0, 0, 1, 0, 0, 0, 32'h0000_0080);
        vecs[7]  = mk(0, 3'b001, 32'h0000_1002, 0, 32'h8001_7FFF, 15, 0, 4'b1100, 32'h1000, 0, 32'hFFFF_8001);
        vecs[8]  = mk(1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 0, 2, 0, 4'b1111, 32'h3000, 32'hCAFE_F00D, 32'hFFFF_8001);
        vecs[9]  = mk(0, 3'b101, 32'h0000_1000, 0, 32'h1234_8765, 3, 0, 4'b0011, 32'h1000, 0, 32'h0000_8765);
        vecs[10] = mk(1, 3'b011, 32'h0000_0000, 0, 0, 0, 1, 0, 0, 0, 32'h0000_8765);
        vecs[11] = mk(0, 3'b110, 32'h0000_0000, 0, 0, 0, 1, 0, 0, 0, 32'h0000_8765);
        for (int i = 0; i < 12; i++) applyStimulus($sformatf("v%0d", i), vecs[i]);
        model_load = 32'h0000_8765;

        // Memory never answers: expect exactly 16 request cycles then one bus_error pulse.
        @(negedge clk);
        mem_read = 1; mem_write = 0; funct3 = 3'b010; alu_result = 32'h0000_4000;
        req_cnt = 0;
        early_err = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            req_cnt += dmem_req ? 1 : 0;
            early_err |= bus_error;
        end
        check("to_reqcnt", req_cnt, 16);
        check("to_early_err", early_err, 0);
        @(posedge clk);
        @(negedge clk);
        check("to_err", bus_error, 1);
        check("to_done", {dmem_req, busy_wait}, 2'b00);
        check("to_load", load_data, model_load);
        mem_read = 0;
        @(posedge clk);
        @(negedge clk);
        check("to_pulse", bus_error, 0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            r.wr    = $urandom_range(0, 1);
            r.f3    = 3'($urandom_range(0, 7));
            r.addr  = $urandom;
            r.sd    = $urandom;
            r.rd    = $urandom;
            r.waits = $urandom_range(0, 4);
            r.exp_mis   = ~legal_m(r.wr, r.f3, r.addr);
            r.exp_be    = be_m(r.f3, r.addr);
            r.exp_addr  = r.addr & 32'hFFFF_FFFC;
            r.exp_wdata = wdata_m(r.f3, r.sd);
            if (!r.exp_mis && !r.wr) model_load = load_m(r.f3, r.addr, r.rd);
            r.exp_load  = model_load;
            applyStimulus($sformatf("rnd%0d", i), r);
        end

        // Asynchronous reset in the middle of an outstanding access.
        @(negedge clk);
        mem_read = 1; mem_write = 0; funct3 = 3'b010; alu_result = 32'h0000_5000;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_pre_req", dmem_req, 1);
        reset = 1'b1;
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_busy", busy_wait, 0);
        check("rst_load", load_data, 0);
        @(negedge clk);
        mem_read = 0;
        reset = 1'b0;
        model_load = 32'd0;
        applyStimulus("post_rst", mk(0, 3'b010, 32'h0000_6008, 0, 32'h0BAD_F00D, 1, 0,
                                     4'b1111, 32'h6008, 0, 32'h0BAD_F00D));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 as store data; drives a word-addressed data-memory handshake with byte strobes; returns sign/zero-extended load data.
- Stalls the pipeline with busy_wait while an access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles in ACCESS waiting for dmem_ready before bus_error (≥1).
- TIMER_W, 5, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_read  input  1  EX/MEM: instruction is a load.
- mem_write  input  1  EX/MEM: instruction is a store (priority over mem_read if both set).
- funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result  input  32  effective address from ALU.
- store_data  input  32  rs2 value for stores.
- dmem_req  output  1  memory request, held until dmem_ready.
- dmem_we  output  1  1 = write.
- dmem_addr  output  32  {alu_result[31:2],2'b00}, registered at issue.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_be  output  4  byte enables.
- dmem_ready  input  1  memory completes access this cycle.
- dmem_rdata  input  32  read word, valid when dmem_ready.
- load_data  output  32  formatted load result.
- busy_wait  output  1  stall request to the pipeline.
- misaligned  output  1  illegal/misaligned access flag (combinational).
- bus_error  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async): state IDLE; dmem_req, dmem_we, dmem_be, busy_wait, bus_error = 0; dmem_addr, dmem_wdata, load_data = 0; timer = 0.
- The FSM has three states: IDLE, ACCESS and DONE.
- IDLE, with (mem_read|mem_write), legal funct3 and aligned address:
  - register addr/we/be/wdata/funct3/addr[1:0];
  - go to ACCESS;
  - busy_wait asserted combinationally in this same cycle.
- IDLE, illegal request:
  - misaligned = 1 combinationally, no dmem_req, busy_wait = 0, stay IDLE.
  - Illegal means: W with addr[1:0]≠0; H/HU with addr[0]≠0; load funct3 ∈ {011,110,111}; store funct3 ≥ 011.
- ACCESS:
  - dmem_req = 1, busy_wait = 1, outputs held stable; timer increments each cycle.
  - dmem_ready = 1: capture formatted dmem_rdata into load_data (loads only), go to DONE, clear timer.
  - timer reaches TIMEOUT−1 without ready: pulse bus_error, drop dmem_req, go to DONE; load_data unchanged.
  - dmem_ready and timeout in the same cycle: ready wins, no bus_error.
- DONE:
  - busy_wait = 0 for exactly one cycle so the pipeline advances; no new issue is allowed (inputs still show the same instruction); next state IDLE.
- Minimum latency: issue cycle + ready cycle + DONE. A 0-wait memory (ready in the first ACCESS cycle) gives 2 stalled cycles.
- Store formatting:
  - SB: wdata = {4{sd[7:0]}}, be = 4'b0001 << a[1:0].
  - SH: wdata = {2{sd[15:0]}}, be = 4'b0011 << a[1:0].
  - SW: wdata = sd, be = 4'b1111.
- Load formatting: select byte/half lane by the registered a[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through. Loads drive be with the same pattern as stores.
- load_data holds its value until the next successful load.
- mem_read = mem_write = 0: unit idle, all handshake outputs 0.
- Reset during ACCESS: dmem_req drops immediately, transaction abandoned, load_data = 0.

Test Plan:
- LW at 0x0000_1004, ready after 2 wait cycles, rdata 0xDEADBEEF -> dmem_addr 0x1004, be 1111, busy_wait high 4 cycles, load_data 0xDEADBEEF.
- LB and LBU at 0x2003, rdata 0x80FF_0102 -> LB load_data 0xFFFF_FF80; LBU 0x0000_0080.
- SB at 0x2002, store_data 0x1234_56AB -> dmem_we=1, be 0100, wdata 0xABAB_ABAB; SH at 0x2002 -> be 1100, wdata 0x56AB_56AB.
- LW at 0x1002 or LH at 0x1001 -> misaligned=1, dmem_req never asserted, busy_wait 0.
- Load with dmem_ready held low, TIMEOUT=16 -> bus_error pulses once after 16 ACCESS cycles, busy_wait releases via DONE, load_data unchanged.
- Reset asserted mid-ACCESS -> dmem_req, busy_wait, load_data = 0 asynchronously; a fresh LW after reset completes normally.
